// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: nibble-serial WIDTH-bit subtractor sequencer.
// A single 4-bit subtract slice is reused once per clock, LSB nibble first,
// with the inter-nibble borrow held in a register.
module sub_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 zero
);

    localparam int unsigned WIDTH  = 4 * NIBBLES;
    localparam int unsigned KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice_res;

    // Nibble select, 4-bit subtract slice (bit 4 is the borrow), and diff merge
    always_comb begin
        a_nib  = 4'd0;
        b_nib  = 4'd0;
        diff_d = diff_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (k_q == KW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        slice_res = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (k_q == KW'(i)) begin
                diff_d[4*i +: 4] = slice_res[3:0];
            end
        end
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        k_q      <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        zero_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= slice_res[4];
                    if (k_q == K_LAST) begin
                        bout_q  <= slice_res[4];
                        zero_q  <= (diff_d == '0);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule
